ioctl_upload_reader: RTL and testbench
======================================

Name: ioctl_upload_reader

Overview:
- Memory-to-host side of the ioctl interface, complementing the boot/ROM download writer that fills SDRAM.
- Services HPS upload requests (ioctl_upload/ioctl_rd) for snapshot/RAM save by reading bytes from the SDRAM port through a req/ack handshake.
- Returns each byte on ioctl_din and holds ioctl_wait high until the byte is valid.
- Sits beside the download path in the top level; its memory request is muxed onto the SDRAM port while the core is held in reset.

Parameters:
- ADDR_W, 23, width of SDRAM byte address (mem_addr)
- BASE_ADDR, 23'h000000, SDRAM address corresponding to ioctl_addr 0
- LIMIT, 25'h020000, upload size in bytes; ioctl_addr >= LIMIT is out of range
- UPLOAD_INDEX, 8'h08, ioctl_index value this block responds to
- FILL_BYTE, 8'hFF, data returned for out-of-range addresses

Ports:
- clk  in  1  system clock (48 MHz)
- reset  in  1  synchronous active-high reset
- ioctl_upload  in  1  upload session active
- ioctl_rd  in  1  one-cycle read strobe, address valid on ioctl_addr
- ioctl_addr  in  25  byte address within upload
- ioctl_index  in  8  file index of the session
- ioctl_din  out  8  byte returned to HPS
- ioctl_wait  out  1  high while requested byte is not yet valid
- bank  in  2  SDRAM bank to read (model select)
- mem_rd  out  1  SDRAM read request, held until mem_ack
- mem_addr  out  ADDR_W  SDRAM byte address, stable while mem_rd is high
- mem_bank  out  2  bank captured at request time
- mem_dout  in  8  SDRAM read data, valid in the mem_ack cycle
- mem_ack  in  1  one-cycle read completion
- active  out  1  high while a session with matching index is open (top-level mux select)
- proto_err  out  1  sticky flag: ioctl_rd seen while ioctl_wait was high

Behaviour:
- Reset: ioctl_din=8'h00, ioctl_wait=0, mem_rd=0, mem_addr=0, mem_bank=0, active=0, proto_err=0; FSM enters IDLE.
- active = ioctl_upload && (ioctl_index == UPLOAD_INDEX), registered with one-cycle latency.
- FSM states: IDLE, FETCH, DONE.
- IDLE: on ioctl_rd && active:
  - Address in range: next cycle ioctl_wait=1, mem_rd=1, mem_addr=BASE_ADDR+ioctl_addr[ADDR_W-1:0] (truncated, wraps modulo 2^ADDR_W), mem_bank=bank; go to FETCH.
  - Address out of range (ioctl_addr >= LIMIT): next cycle ioctl_din=FILL_BYTE, ioctl_wait stays 0, no memory access; go to DONE.
- FETCH: mem_rd and mem_addr are held until the mem_ack cycle. In that cycle ioctl_din<=mem_dout. Next cycle mem_rd=0, ioctl_wait=0; go to DONE.
  - Latency for a hit: ioctl_wait rises 1 cycle after the ioctl_rd strobe and falls 1 cycle after mem_ack.
- DONE: ioctl_din holds its value until the next accepted ioctl_rd. Behaves as IDLE for a new strobe.
- ioctl_rd while ioctl_wait=1: strobe is ignored, proto_err<=1. proto_err clears only on reset or on the rising edge of active.
- ioctl_rd while not active: ignored; no error.
- Session end (active falls) during FETCH: mem_rd stays high until mem_ack, so the SDRAM transaction is never truncated. Returned data is discarded, ioctl_wait<=0, FSM goes to IDLE.
- Simultaneous mem_ack and new ioctl_rd: the ack is serviced and the strobe is treated as a protocol error.
- Reset in FETCH: all outputs return to their reset values next cycle. The outstanding ack is ignored.

Optional Feature:
- Macro UPLOAD_PREFETCH_EN.
- Defined:
  - After each served byte, the block issues a read of addr+1 into a one-byte prefetch register tagged with its address.
  - An ioctl_rd matching the tag (valid, ack received) returns the byte next cycle with ioctl_wait never asserted.
  - A tag miss, or a prefetch still outstanding, behaves as FETCH. An outstanding prefetch is completed first, then the demand read is issued.
  - The tag is invalidated on session end and on reset.
  - No prefetch is issued for addresses >= LIMIT.
- Undefined: every in-range read costs a full FETCH.

Decomposition:
- Package ioctl_pkg holds:
  - ioctl index constants (ROM 0-3, TAPE 4, CPR 5, BIN 6, UPLOAD 8)
  - IOCTL_ADDR_W = 25
  - the FSM state enum
- One natural sub-module, ioctl_prefetch_buf: tag register, data register, valid flag and hit compare. It is instantiated only under UPLOAD_PREFETCH_EN.

Test Plan:
- Index 8, ioctl_rd at addr 0x00010, memory acks 4 cycles after mem_rd with 8'hA5 -> mem_addr=0x000010; wait high 1 cycle after strobe, low 1 cycle after ack; ioctl_din=8'hA5.
- ioctl_rd at addr 0x020000 (=LIMIT) -> mem_rd never asserts, ioctl_wait stays 0, ioctl_din=8'hFF.
- Second ioctl_rd issued while wait is high -> proto_err=1; first read still completes with its data; new session rising edge clears proto_err.
- ioctl_index=4 with ioctl_upload=1, ioctl_rd pulses -> active=0, no mem_rd, ioctl_wait=0.
- ioctl_upload dropped mid-FETCH, ack 3 cycles later -> mem_rd held until ack, then 0; ioctl_din unchanged; FSM in IDLE.
- UPLOAD_PREFETCH_EN defined, sequential reads at 0,1,2 -> first read waits, reads 1 and 2 return with ioctl_wait=0 and correct data.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared ioctl file-index constants, address width and the upload reader FSM state.
package ioctl_pkg;

   localparam int IOCTL_ADDR_W = 25;

   localparam logic [7:0] IDX_ROM0   = 8'h00;
   localparam logic [7:0] IDX_ROM1   = 8'h01;
   localparam logic [7:0] IDX_ROM2   = 8'h02;
   localparam logic [7:0] IDX_ROM3   = 8'h03;
   localparam logic [7:0] IDX_TAPE   = 8'h04;
   localparam logic [7:0] IDX_CPR    = 8'h05;
   localparam logic [7:0] IDX_BIN    = 8'h06;
   localparam logic [7:0] IDX_UPLOAD = 8'h08;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } upl_state_t;

endpackage

// File: rtl/ioctl_prefetch_buf.sv
// One-byte prefetch register tagged with its upload address; hit is combinational.
// Cleared for the whole time no session is open.
module ioctl_prefetch_buf
   import ioctl_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_clr,
   input  logic                    i_load,
   input  logic [IOCTL_ADDR_W-1:0] i_load_tag,
   input  logic [7:0]              i_load_dat,
   input  logic [IOCTL_ADDR_W-1:0] i_look_addr,
   output logic                    o_hit,
   output logic [7:0]              o_dat
);

   logic                    r_vld;
   logic [IOCTL_ADDR_W-1:0] r_tag;
   logic [7:0]              r_dat;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_vld <= 1'b0;
         r_tag <= '0;
         r_dat <= '0;
      end else if (i_load) begin
         r_vld <= 1'b1;
         r_tag <= i_load_tag;
         r_dat <= i_load_dat;
      end
   end

   assign o_hit = r_vld && (r_tag == i_look_addr);
   assign o_dat = r_dat;

endmodule

// File: rtl/ioctl_upload_reader.sv
// HPS upload reader: serves ioctl_rd strobes from SDRAM via mem_rd/mem_ack, out-of-range reads return FILL_BYTE.
// Optional UPLOAD_PREFETCH_EN keeps the next sequential byte in a tagged one-byte buffer.
module ioctl_upload_reader
   import ioctl_pkg::*;
#(
   parameter int                      ADDR_W       = 23,
   parameter logic [ADDR_W-1:0]       BASE_ADDR    = '0,
   parameter logic [IOCTL_ADDR_W-1:0] LIMIT        = 25'h020000,
   parameter logic [7:0]              UPLOAD_INDEX = IDX_UPLOAD,
   parameter logic [7:0]              FILL_BYTE    = 8'hFF
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ioctl_upload,
   input  logic                    ioctl_rd,
   input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]              ioctl_index,
   output logic [7:0]              ioctl_din,
   output logic                    ioctl_wait,
   input  logic [1:0]              bank,
   output logic                    mem_rd,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [1:0]              mem_bank,
   input  logic [7:0]              mem_dout,
   input  logic                    mem_ack,
   output logic                    active,
   output logic                    proto_err
);

   upl_state_t        r_state;
   logic              r_active;
   logic [7:0]        r_din;
   logic              r_wait;
   logic              r_mem_rd;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [1:0]        r_mem_bank;
   logic              r_proto_err;
   logic              r_drain;
   logic              r_hold;
   logic [ADDR_W-1:0] r_req_mem;
   logic [1:0]        r_req_bank;

   logic              w_active_now;
   logic              w_strobe;
   logic              w_in_range;
   logic [ADDR_W-1:0] w_mem_addr_req;

   assign w_active_now   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
   assign w_strobe       = ioctl_rd && r_active;
   assign w_in_range     = (ioctl_addr < LIMIT);
   assign w_mem_addr_req = BASE_ADDR + ioctl_addr[ADDR_W-1:0];

`ifdef UPLOAD_PREFETCH_EN
   logic                    r_pf_pend;
   logic [IOCTL_ADDR_W-1:0] r_pf_addr;
   logic [IOCTL_ADDR_W-1:0] r_req_addr;
   logic [IOCTL_ADDR_W-1:0] w_serve_addr;
   logic [IOCTL_ADDR_W-1:0] w_next_addr;
   logic                    w_next_ok;
   logic [ADDR_W-1:0]       w_next_mem;
   logic                    w_pf_hit;
   logic [7:0]              w_pf_dat;
   logic                    w_pf_load;

   assign w_serve_addr = (r_state == ST_FETCH) ? r_req_addr : ioctl_addr;
   assign w_next_addr  = w_serve_addr + 25'd1;
   assign w_next_ok    = (w_next_addr < LIMIT);
   assign w_next_mem   = BASE_ADDR + w_next_addr[ADDR_W-1:0];
   // A prefetch that outlives its session is dropped on arrival, never loaded.
   assign w_pf_load    = mem_ack && r_pf_pend && r_active;

   ioctl_prefetch_buf u_pf (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_clr       (!r_active),
      .i_load      (w_pf_load),
      .i_load_tag  (r_pf_addr),
      .i_load_dat  (mem_dout),
      .i_look_addr (ioctl_addr),
      .o_hit       (w_pf_hit),
      .o_dat       (w_pf_dat)
   );
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_active    <= 1'b0;
         r_din       <= 8'h00;
         r_wait      <= 1'b0;
         r_mem_rd    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_bank  <= 2'd0;
         r_proto_err <= 1'b0;
         r_drain     <= 1'b0;
         r_hold      <= 1'b0;
         r_req_mem   <= '0;
         r_req_bank  <= 2'd0;
`ifdef UPLOAD_PREFETCH_EN
         r_pf_pend   <= 1'b0;
         r_pf_addr   <= '0;
         r_req_addr  <= '0;
`endif
      end else begin
         r_active <= w_active_now;

         if (w_active_now && !r_active)
            r_proto_err <= 1'b0;
         else if (w_strobe && r_wait)
            r_proto_err <= 1'b1;

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (mem_ack && r_mem_rd) begin
                  r_mem_rd <= 1'b0;
`ifdef UPLOAD_PREFETCH_EN
                  r_pf_pend <= 1'b0;
`endif
               end
`ifdef UPLOAD_PREFETCH_EN
               if (!r_active)
                  r_pf_pend <= 1'b0;
`endif
               if (w_strobe) begin
                  if (!w_in_range) begin
                     r_din   <= FILL_BYTE;
                     r_state <= ST_DONE;
                  end
`ifdef UPLOAD_PREFETCH_EN
                  else if (w_pf_hit && !r_pf_pend) begin
                     r_din   <= w_pf_dat;
                     r_state <= ST_DONE;
                     if (w_next_ok) begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_next_mem;
                        r_mem_bank <= bank;
                        r_pf_pend  <= 1'b1;
                        r_pf_addr  <= w_next_addr;
                     end
                  end
`endif
                  else begin
                     r_wait     <= 1'b1;
                     r_req_mem  <= w_mem_addr_req;
                     r_req_bank <= bank;
                     r_state    <= ST_FETCH;
`ifdef UPLOAD_PREFETCH_EN
                     r_req_addr <= ioctl_addr;
`endif
                     // An access still in flight must finish before the demand read goes out.
                     if (r_mem_rd && !mem_ack)
                        r_hold <= 1'b1;
                     else begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_mem_addr_req;
                        r_mem_bank <= bank;
                     end
                  end
               end
            end

            ST_FETCH: begin
               if (mem_ack) begin
                  if (r_drain || !r_active) begin
                     r_mem_rd <= 1'b0;
                     r_wait   <= 1'b0;
                     r_drain  <= 1'b0;
                     r_hold   <= 1'b0;
                     r_state  <= ST_IDLE;
`ifdef UPLOAD_PREFETCH_EN
                     r_pf_pend <= 1'b0;
`endif
                  end else if (r_hold) begin
                     r_hold     <= 1'b0;
                     r_mem_rd   <= 1'b1;
                     r_mem_addr <= r_req_mem;
                     r_mem_bank <= r_req_bank;
`ifdef UPLOAD_PREFETCH_EN
                     r_pf_pend  <= 1'b0;
`endif
                  end else begin
                     r_mem_rd <= 1'b0;
                     r_wait   <= 1'b0;
                     r_din    <= mem_dout;
                     r_state  <= ST_DONE;
`ifdef UPLOAD_PREFETCH_EN
                     if (w_next_ok) begin
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_next_mem;
                        r_mem_bank <= bank;
                        r_pf_pend  <= 1'b1;
                        r_pf_addr  <= w_next_addr;
                     end
`endif
                  end
               end else if (!r_active) begin
                  // Session gone: release the host now, keep the SDRAM request up until its ack.
                  r_wait  <= 1'b0;
                  r_drain <= 1'b1;
`ifdef UPLOAD_PREFETCH_EN
                  r_pf_pend <= 1'b0;
`endif
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ioctl_din  = r_din;
   assign ioctl_wait = r_wait;
   assign mem_rd     = r_mem_rd;
   assign mem_addr   = r_mem_addr;
   assign mem_bank   = r_mem_bank;
   assign active     = r_active;
   assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader with hand-computed expectations.
module tb_ioctl_upload_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_index;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic [1:0]  bank;
   logic        mem_rd;
   logic [22:0] mem_addr;
   logic [1:0]  mem_bank;
   logic [7:0]  mem_dout;
   logic        mem_ack;
   logic        active;
   logic        proto_err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   ioctl_upload_reader dut (
      .clk          (clk),
      .reset        (reset),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_index  (ioctl_index),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .bank         (bank),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_bank     (mem_bank),
      .mem_dout     (mem_dout),
      .mem_ack      (mem_ack),
      .active       (active),
      .proto_err    (proto_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [24:0] a);
      ioctl_rd   = 1'b1;
      ioctl_addr = a;
      tick();
      ioctl_rd   = 1'b0;
   endtask

   task automatic ack(input logic [7:0] d);
      mem_ack  = 1'b1;
      mem_dout = d;
      tick();
      mem_ack  = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      ioctl_upload = 1'b0;
      ioctl_rd     = 1'b0;
      ioctl_addr   = '0;
      ioctl_index  = 8'h00;
      bank         = 2'd0;
      mem_dout     = 8'h00;
      mem_ack      = 1'b0;
      repeat (3) tick();

      check("rst_din",   {24'd0, ioctl_din}, 32'h00);
      check("rst_wait",  {31'd0, ioctl_wait}, 32'd0);
      check("rst_memrd", {31'd0, mem_rd}, 32'd0);
      check("rst_addr",  {9'd0, mem_addr}, 32'd0);
      check("rst_bank",  {30'd0, mem_bank}, 32'd0);
      check("rst_act",   {31'd0, active}, 32'd0);
      check("rst_perr",  {31'd0, proto_err}, 32'd0);
      reset = 1'b0;

      ioctl_upload = 1'b1;
      ioctl_index  = 8'h08;
      tick();
      check("act_rise", {31'd0, active}, 32'd1);

`ifdef UPLOAD_PREFETCH_EN
      strobe(25'h0);
      check("pf0_wait", {31'd0, ioctl_wait}, 32'd1);
      ack(8'h10);
      check("pf0_din",   {24'd0, ioctl_din}, 32'h10);
      check("pf0_wlow",  {31'd0, ioctl_wait}, 32'd0);
      check("pf1_issue", {31'd0, mem_rd}, 32'd1);
      check("pf1_addr",  {9'd0, mem_addr}, 32'h1);
      ack(8'h11);
      check("pf1_done", {31'd0, mem_rd}, 32'd0);
      strobe(25'h1);
      check("pf1_wait", {31'd0, ioctl_wait}, 32'd0);
      check("pf1_din",  {24'd0, ioctl_din}, 32'h11);
      check("pf2_addr", {9'd0, mem_addr}, 32'h2);
      ack(8'h12);
      strobe(25'h2);
      check("pf2_wait", {31'd0, ioctl_wait}, 32'd0);
      check("pf2_din",  {24'd0, ioctl_din}, 32'h12);
`else
      // Basic hit, ack 4 cycles after mem_rd
      bank = 2'd2;
      strobe(25'h10);
      check("t1_wait",  {31'd0, ioctl_wait}, 32'd1);
      check("t1_memrd", {31'd0, mem_rd}, 32'd1);
      check("t1_addr",  {9'd0, mem_addr}, 32'h10);
      check("t1_bank",  {30'd0, mem_bank}, 32'd2);
      repeat (3) tick();
      check("t1_whold", {31'd0, ioctl_wait}, 32'd1);
      check("t1_rhold", {31'd0, mem_rd}, 32'd1);
      ack(8'hA5);
      check("t1_wlow",  {31'd0, ioctl_wait}, 32'd0);
      check("t1_rdlow", {31'd0, mem_rd}, 32'd0);
      check("t1_din",   {24'd0, ioctl_din}, 32'hA5);

      // Out of range at exactly LIMIT
      strobe(25'h020000);
      check("t2_memrd", {31'd0, mem_rd}, 32'd0);
      check("t2_wait",  {31'd0, ioctl_wait}, 32'd0);
      check("t2_din",   {24'd0, ioctl_din}, 32'hFF);
      tick();
      check("t2_norq",  {31'd0, mem_rd}, 32'd0);

      // Last in-range byte
      strobe(25'h01FFFF);
      check("t2b_wait", {31'd0, ioctl_wait}, 32'd1);
      check("t2b_addr", {9'd0, mem_addr}, 32'h1FFFF);
      ack(8'h3C);
      check("t2b_din",  {24'd0, ioctl_din}, 32'h3C);

      // Strobe while waiting
      strobe(25'h20);
      check("t3_wait", {31'd0, ioctl_wait}, 32'd1);
      strobe(25'h30);
      check("t3_perr", {31'd0, proto_err}, 32'd1);
      check("t3_addr", {9'd0, mem_addr}, 32'h20);
      ack(8'h5A);
      check("t3_din",   {24'd0, ioctl_din}, 32'h5A);
      check("t3_wlow",  {31'd0, ioctl_wait}, 32'd0);
      check("t3_stick", {31'd0, proto_err}, 32'd1);
      ioctl_upload = 1'b0;
      tick();
      tick();
      check("t3_actlo", {31'd0, active}, 32'd0);
      check("t3_perrk", {31'd0, proto_err}, 32'd1);
      ioctl_upload = 1'b1;
      tick();
      check("t3_acthi", {31'd0, active}, 32'd1);
      check("t3_clr",   {31'd0, proto_err}, 32'd0);

      // Ack and new strobe in the same cycle
      strobe(25'h40);
      mem_ack    = 1'b1;
      mem_dout   = 8'h77;
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'h50;
      tick();
      mem_ack    = 1'b0;
      ioctl_rd   = 1'b0;
      check("t3b_perr",  {31'd0, proto_err}, 32'd1);
      check("t3b_din",   {24'd0, ioctl_din}, 32'h77);
      check("t3b_wait",  {31'd0, ioctl_wait}, 32'd0);
      check("t3b_memrd", {31'd0, mem_rd}, 32'd0);
      tick();
      check("t3b_ign",   {31'd0, mem_rd}, 32'd0);
      ioctl_upload = 1'b0;
      tick();
      ioctl_upload = 1'b1;
      tick();
      check("t3b_clr", {31'd0, proto_err}, 32'd0);

      // Foreign index
      ioctl_index = 8'h04;
      tick();
      check("t4_act", {31'd0, active}, 32'd0);
      strobe(25'h10);
      check("t4_memrd", {31'd0, mem_rd}, 32'd0);
      check("t4_wait",  {31'd0, ioctl_wait}, 32'd0);
      check("t4_perr",  {31'd0, proto_err}, 32'd0);
      tick();
      check("t4_norq",  {31'd0, mem_rd}, 32'd0);

      // Session ends mid-fetch, ack 3 cycles after the drop
      ioctl_index = 8'h08;
      tick();
      bank = 2'd1;
      strobe(25'h60);
      check("t5_memrd", {31'd0, mem_rd}, 32'd1);
      check("t5_bank",  {30'd0, mem_bank}, 32'd1);
      ioctl_upload = 1'b0;
      tick();
      check("t5_actlo", {31'd0, active}, 32'd0);
      check("t5_rdhi1", {31'd0, mem_rd}, 32'd1);
      tick();
      check("t5_wlow",  {31'd0, ioctl_wait}, 32'd0);
      check("t5_rdhi2", {31'd0, mem_rd}, 32'd1);
      ack(8'hEE);
      check("t5_rdlow", {31'd0, mem_rd}, 32'd0);
      check("t5_din",   {24'd0, ioctl_din}, 32'h77);
      ioctl_upload = 1'b1;
      tick();
      strobe(25'h70);
      check("t5_idle_rd",   {31'd0, mem_rd}, 32'd1);
      check("t5_idle_addr", {9'd0, mem_addr}, 32'h70);
      check("t5_idle_wait", {31'd0, ioctl_wait}, 32'd1);
      ack(8'h11);
      check("t5_idle_din",  {24'd0, ioctl_din}, 32'h11);

      // Reset while fetching
      strobe(25'h80);
      check("t6_memrd", {31'd0, mem_rd}, 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6_din",   {24'd0, ioctl_din}, 32'h00);
      check("t6_wait",  {31'd0, ioctl_wait}, 32'd0);
      check("t6_rdlow", {31'd0, mem_rd}, 32'd0);
      check("t6_act",   {31'd0, active}, 32'd0);
      ack(8'h99);
      check("t6_ackign", {24'd0, ioctl_din}, 32'h00);
      check("t6_norq",   {31'd0, mem_rd}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
